melody_sequencer: RTL and testbench

Drives the 4-bit note input of the music tone generator. Plays a stored song of (note, duration) entries with a fixed inter-note gap, with optional looping. Shares the tone generator with a sound-effect requester: an accepted effect pre-empts the melody, which freezes and then resumes where it stopped. The block sits between game-control logic and the tone generator; its note output connects directly to the generator's note port.

---
 rtl/melody_sequencer_pkg.sv | 33 +++
 rtl/melody_sequencer_song_rom.sv | 23 ++
 rtl/melody_sequencer.sv | 165 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: note coding, song ROM entry layout
// and the melody state encoding.
package melody_sequencer_pkg;

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C1   = 4'd1,
        NOTE_D1   = 4'd2,
        NOTE_E1   = 4'd3,
        NOTE_F1   = 4'd4,
        NOTE_G1   = 4'd5,
        NOTE_A1   = 4'd6,
        NOTE_B1   = 4'd7
    } note_e;

    localparam int          NOTE_OCT_BIT = 3;
    localparam int          FIELD_W      = 4;
    localparam int          ENTRY_NOTE_LSB = 4;
    localparam int          ENTRY_DUR_LSB  = 0;
    localparam logic [3:0]  END_MARK     = 4'd0;

    typedef enum logic [1:0] {
        MEL_IDLE  = 2'd0,
        MEL_FETCH = 2'd1,
        MEL_PLAY  = 2'd2,
        MEL_GAP   = 2'd3
    } mel_state_e;

    function automatic logic [7:0] rom_entry(input logic [3:0] note, input logic [3:0] dur);
        return {note, dur};
    endfunction

endpackage

// File: rtl/melody_sequencer_song_rom.sv
// Combinational song table: {note, dur} per entry, dur of zero marks the end.
module song_rom
    import melody_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [7:0]        entry_o
);

    always_comb begin
        entry_o = rom_entry(NOTE_REST, END_MARK);
        case (addr_i)
            ADDR_W'(0): entry_o = rom_entry(NOTE_C1, 4'd2);
            ADDR_W'(1): entry_o = rom_entry(NOTE_E1, 4'd1);
            ADDR_W'(2): entry_o = rom_entry(NOTE_REST, END_MARK);
            // spare slot past the end marker, reserved for a longer tune
            ADDR_W'(3): entry_o = rom_entry(NOTE_C1 | (4'd1 << NOTE_OCT_BIT), 4'd1);
            default:    entry_o = rom_entry(NOTE_REST, END_MARK);
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the song ROM onto the tone generator note port, with a pre-emptive
// sound-effect channel that freezes the melody while it sounds.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int TICK_DIV  = 15625,
    parameter int GAP_TICKS = 1,
    parameter int ADDR_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              play_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic              sfx_req_i,
    input  logic [3:0]        sfx_note_i,
    input  logic [3:0]        sfx_dur_i,
    output logic              sfx_ack_o,
    output logic [3:0]        note_o,
    output logic              busy_o,
    output logic              song_end_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic              tick;

    mel_state_e        mel_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wrap_q;
    logic [3:0]        cur_note_q;
    logic [3:0]        dur_cnt_q;
    logic [7:0]        gap_cnt_q;

    logic              sfx_active_q;
    logic [3:0]        sfx_note_q;
    logic [3:0]        sfx_cnt_q;

    logic [3:0]        note_q;
    logic              busy_q;
    logic              song_end_q;

    logic [7:0]        entry;
    logic [3:0]        rom_note, rom_dur;
    logic              at_end;

    song_rom #(.ADDR_W(ADDR_W)) u_rom (
        .addr_i  (addr_q),
        .entry_o (entry)
    );

    assign rom_note = entry[ENTRY_NOTE_LSB +: FIELD_W];
    assign rom_dur  = entry[ENTRY_DUR_LSB  +: FIELD_W];
    // stepping off the top of the ROM is treated as hitting an end marker
    assign at_end   = wrap_q | (rom_dur == END_MARK);

    assign tick       = (tick_cnt_q == 16'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tick_cnt_q <= 16'd0;
        else          tick_cnt_q <= tick_cnt_d;
    end

    assign sfx_ack_o = sfx_req_i & ~sfx_active_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sfx_active_q <= 1'b0;
            sfx_note_q   <= 4'd0;
            sfx_cnt_q    <= 4'd0;
        end else if (sfx_active_q) begin
            if (tick) begin
                if (sfx_cnt_q <= 4'd1) sfx_active_q <= 1'b0;
                else                   sfx_cnt_q    <= sfx_cnt_q - 4'd1;
            end
        end else if (sfx_req_i) begin
            sfx_active_q <= 1'b1;
            sfx_note_q   <= sfx_note_i;
            sfx_cnt_q    <= (sfx_dur_i == 4'd0) ? 4'd1 : sfx_dur_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mel_q      <= MEL_IDLE;
            addr_q     <= '0;
            wrap_q     <= 1'b0;
            cur_note_q <= 4'd0;
            dur_cnt_q  <= 4'd0;
            gap_cnt_q  <= 8'd0;
            note_q     <= 4'd0;
            busy_q     <= 1'b0;
            song_end_q <= 1'b0;
        end else begin
            song_end_q <= 1'b0;
            note_q     <= sfx_active_q ? sfx_note_q
                        : (mel_q == MEL_PLAY) ? cur_note_q : NOTE_REST;
            busy_q     <= (mel_q != MEL_IDLE) | sfx_active_q;

            if (stop_i) begin
                mel_q  <= MEL_IDLE;
                addr_q <= '0;
                wrap_q <= 1'b0;
            end else if (play_i) begin
                mel_q  <= MEL_FETCH;
                addr_q <= '0;
                wrap_q <= 1'b0;
            end else if (!sfx_active_q) begin
                unique case (mel_q)
                    MEL_IDLE: ;
                    MEL_FETCH: begin
                        if (at_end) begin
                            addr_q <= '0;
                            wrap_q <= 1'b0;
                            // an end marker at entry 0 must not loop forever
                            if (!(loop_i && (addr_q != '0))) begin
                                mel_q      <= MEL_IDLE;
                                song_end_q <= 1'b1;
                            end
                        end else begin
                            cur_note_q <= rom_note;
                            dur_cnt_q  <= rom_dur;
                            mel_q      <= MEL_PLAY;
                        end
                    end
                    MEL_PLAY: begin
                        if (tick) begin
                            if (dur_cnt_q <= 4'd1) begin
                                if (GAP_TICKS > 0) begin
                                    mel_q     <= MEL_GAP;
                                    gap_cnt_q <= 8'(GAP_TICKS);
                                end else begin
                                    mel_q <= MEL_FETCH;
                                    if (addr_q == '1) wrap_q <= 1'b1;
                                    else              addr_q <= addr_q + ADDR_W'(1);
                                end
                            end else begin
                                dur_cnt_q <= dur_cnt_q - 4'd1;
                            end
                        end
                    end
                    MEL_GAP: begin
                        if (tick) begin
                            if (gap_cnt_q <= 8'd1) begin
                                mel_q <= MEL_FETCH;
                                if (addr_q == '1) wrap_q <= 1'b1;
                                else              addr_q <= addr_q + ADDR_W'(1);
                            end else begin
                                gap_cnt_q <= gap_cnt_q - 8'd1;
                            end
                        end
                    end
                    default: mel_q <= MEL_IDLE;
                endcase
            end
        end
    end

    assign note_o     = note_q;
    assign busy_o     = busy_q;
    assign song_end_o = song_end_q;
    assign addr_o     = addr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed and randomized checks of melody_sequencer against a tick-level
// behavioural model of the song player and effect channel.
module tb_melody_sequencer;

    localparam int TD  = 4;
    localparam int GAP = 1;
    localparam int AW  = 5;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_SOUND = 2, PH_SILENCE = 3;

    logic          clk = 1'b1;
    logic          rst_n;
    logic          tb_play, tb_stop, tb_loop, tb_sfx_req;
    logic [3:0]    tb_sfx_note, tb_sfx_dur;
    logic          sfx_ack, busy, song_end;
    logic [3:0]    note;
    logic [AW-1:0] addr;

    int total = 0;
    int bad   = 0;

    // reference model state
    int       m_ph, m_pos, m_len, m_el, m_tc;
    logic [3:0] m_cur;
    bit       m_sfx_on;
    logic [3:0] m_sfx_note;
    int       m_sfx_len, m_sfx_ticks;
    logic [3:0] m_note_o;
    bit       m_busy_o, m_end_o;
    int       end_pulses;

    always #5 clk = ~clk;

    melody_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GAP), .ADDR_W(AW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .play_i     (tb_play),
        .stop_i     (tb_stop),
        .loop_i     (tb_loop),
        .sfx_req_i  (tb_sfx_req),
        .sfx_note_i (tb_sfx_note),
        .sfx_dur_i  (tb_sfx_dur),
        .sfx_ack_o  (sfx_ack),
        .note_o     (note),
        .busy_o     (busy),
        .song_end_o (song_end),
        .addr_o     (addr)
    );

    function automatic int song_dur(input int pos);
        case (pos)
            0: return 2;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] song_note(input int pos);
        case (pos)
            0: return 4'd1;
            1: return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_pos = 0; m_len = 0; m_el = 0; m_tc = 0; m_cur = 0;
        m_sfx_on = 0; m_sfx_note = 0; m_sfx_len = 0; m_sfx_ticks = 0;
        m_note_o = 0; m_busy_o = 0; m_end_o = 0;
    endtask

    task automatic next_entry();
        m_pos++;
        m_ph = PH_FETCH;
    endtask

    task automatic model_edge();
        bit tick, frozen;
        tick   = (m_tc == TD - 1);
        frozen = m_sfx_on;
        m_note_o = m_sfx_on ? m_sfx_note : (m_ph == PH_SOUND ? m_cur : 4'd0);
        m_busy_o = (m_ph != PH_IDLE) || m_sfx_on;
        m_end_o  = 0;

        if (m_sfx_on) begin
            if (tick) begin
                m_sfx_ticks++;
                if (m_sfx_ticks >= m_sfx_len) m_sfx_on = 0;
            end
        end else if (tb_sfx_req) begin
            m_sfx_on    = 1;
            m_sfx_note  = tb_sfx_note;
            m_sfx_len   = (tb_sfx_dur == 0) ? 1 : int'(tb_sfx_dur);
            m_sfx_ticks = 0;
        end

        if (tb_stop) begin
            m_ph = PH_IDLE; m_pos = 0;
        end else if (tb_play) begin
            m_ph = PH_FETCH; m_pos = 0;
        end else if (!frozen) begin
            case (m_ph)
                PH_FETCH: begin
                    if (m_pos >= (1 << AW) || song_dur(m_pos) == 0) begin
                        if (tb_loop && m_pos != 0) m_pos = 0;
                        else begin
                            m_ph = PH_IDLE; m_pos = 0; m_end_o = 1; end_pulses++;
                        end
                    end else begin
                        m_cur = song_note(m_pos);
                        m_len = song_dur(m_pos);
                        m_el  = 0;
                        m_ph  = PH_SOUND;
                    end
                end
                PH_SOUND: if (tick) begin
                    m_el++;
                    if (m_el >= m_len) begin
                        if (GAP > 0) begin m_ph = PH_SILENCE; m_el = 0; end
                        else next_entry();
                    end
                end
                PH_SILENCE: if (tick) begin
                    m_el++;
                    if (m_el >= GAP) next_entry();
                end
                default: ;
            endcase
        end
        m_tc = tick ? 0 : m_tc + 1;
    endtask

    task automatic check_outputs(input string pfx);
        int ea;
        ea = (m_pos > (1 << AW) - 1) ? (1 << AW) - 1 : m_pos;
        check({pfx, ".note"},     8'(note),     8'(m_note_o));
        check({pfx, ".busy"},     8'(busy),     8'(m_busy_o));
        check({pfx, ".song_end"}, 8'(song_end), 8'(m_end_o));
        check({pfx, ".addr"},     8'(addr),     8'(ea));
    endtask

    // called at a negedge; leaves time at the following negedge
    task automatic cycle(input string pfx, input bit p, input bit s, input bit rq,
                         input logic [3:0] sn, input logic [3:0] sd);
        tb_play = p; tb_stop = s; tb_sfx_req = rq; tb_sfx_note = sn; tb_sfx_dur = sd;
        #1;
        check({pfx, ".sfx_ack"}, 8'(sfx_ack), 8'(rq && !m_sfx_on));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(pfx);
    endtask

    task automatic idle_cycles(input string pfx, input int n);
        for (int i = 0; i < n; i++) cycle(pfx, 0, 0, 0, 4'd0, 4'd1);
    endtask

    task automatic async_reset(input string pfx);
        tb_play = 0; tb_stop = 0; tb_sfx_req = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check({pfx, ".rst_note"},     8'(note),     8'd0);
        check({pfx, ".rst_busy"},     8'(busy),     8'd0);
        check({pfx, ".rst_song_end"}, 8'(song_end), 8'd0);
        check({pfx, ".rst_addr"},     8'(addr),     8'd0);
        check({pfx, ".rst_sfx_ack"},  8'(sfx_ack),  8'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int reached;
        rst_n = 1'b0;
        tb_play = 0; tb_stop = 0; tb_loop = 0; tb_sfx_req = 0;
        tb_sfx_note = 0; tb_sfx_dur = 0;
        end_pulses = 0;
        model_reset();

        @(negedge clk);
        check_outputs("reset");
        check("reset.sfx_ack", 8'(sfx_ack), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // one pass of the song, no loop
        tb_loop = 0;
        cycle("s1", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s1", 40);
        check("s1.end_count", 8'(end_pulses), 8'd1);

        // looping: three full passes with no end pulse
        tb_loop = 1;
        end_pulses = 0;
        cycle("s2", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s2", 75);
        check("s2.end_count", 8'(end_pulses), 8'd0);
        cycle("s2", 0, 1, 0, 4'd0, 4'd1);
        tb_loop = 0;

        // effect pre-empting a playing note, second request ignored
        cycle("s3", 1, 0, 0, 4'd0, 4'd1);
        reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            if (m_ph == PH_SOUND && m_el == 1) reached = 1;
            else cycle("s3", 0, 0, 0, 4'd0, 4'd1);
        end
        check("s3.reach_play", 8'(reached), 8'd1);
        cycle("s3", 0, 0, 1, 4'd7, 4'd3);
        cycle("s3", 0, 0, 1, 4'd5, 4'd2);
        idle_cycles("s3", 35);

        // effect from idle, octave note
        cycle("s4", 0, 0, 1, 4'd9, 4'd2);
        idle_cycles("s4", 12);

        // stop+play together, then restart mid-song
        cycle("s5", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s5", 6);
        cycle("s5", 1, 1, 0, 4'd0, 4'd1);
        idle_cycles("s5", 3);
        cycle("s5", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s5", 12);
        cycle("s5", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s5", 6);

        // asynchronous reset mid-play and mid-effect
        async_reset("s6a");
        idle_cycles("s6a", 6);
        cycle("s6", 1, 0, 0, 4'd0, 4'd1);
        idle_cycles("s6", 4);
        cycle("s6", 0, 0, 1, 4'd6, 4'd4);
        idle_cycles("s6", 3);
        async_reset("s6b");
        idle_cycles("s6b", 6);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            bit p, s, rq;
            if ($urandom_range(0, 49) == 0) tb_loop = ~tb_loop;
            p  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 59) == 0);
            rq = ($urandom_range(0, 11) == 0);
            cycle("rnd", p, s, rq, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
